// File: rtl/sys_array_result_collector.sv
// Realigns lane-skewed systolic-array outputs into whole result vectors, buffers them in a
// credit-protected FIFO and streams them out. Optional ReLU clamp: define SYS_COLLECT_RELU_EN.
module sys_array_result_collector #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4,
    parameter int PIPE_LAT   = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_W      = 16
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    start,
    input  logic [LEN_W-1:0]                        frame_len,
    input  logic                                    vec_valid,
    output logic                                    vec_ready,
    input  logic [LANES-1:0][2*DATA_WIDTH-1:0]      array_out,
    output logic                                    res_valid,
    input  logic                                    res_ready,
    output logic [LANES-1:0][2*DATA_WIDTH-1:0]      res_data,
    output logic                                    res_last,
    output logic                                    busy,
    output logic                                    done
);

    localparam int RW    = 2 * DATA_WIDTH;
    localparam int TL    = PIPE_LAT + LANES - 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(FIFO_DEPTH + TL + 1) + 1;
    localparam int EW    = LANES * RW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [LEN_W-1:0]        frame_len_q, frame_len_d;
    logic [LEN_W-1:0]        issued_q, issued_d;
    logic [LEN_W-1:0]        written_q, written_d;
    logic [TL-1:0]           tag_q, tag_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0]        mem_cnt_q, mem_cnt_d;
    logic                    res_valid_q, res_valid_d;
    logic                    res_last_q, res_last_d;
    logic [LANES-1:0][RW-1:0] res_data_q, res_data_d;
    logic                    done_q, done_d;
    logic [EW-1:0]           mem_q [FIFO_DEPTH];

    logic [LANES-1:0][RW-1:0] aligned;
    logic [LANES-1:0][RW-1:0] wr_data;
    logic [OCC_W-1:0]        inflight;
    logic [OCC_W-1:0]        fifo_cnt;
    logic                    issue, wr_en, wr_last, pop, load_out, mem_we, mem_rd;

    // Lane t arrives t cycles after lane 0, so it needs LANES-1-t stages to line up.
    for (genvar t = 0; t < LANES; t++) begin : g_deskew
        localparam int N = LANES - 1 - t;
        if (N == 0) begin : g_direct
            assign aligned[t] = array_out[t];
        end else begin : g_delay
            logic [RW-1:0] dly_q [N];
            logic [RW-1:0] dly_d [N];
            always_comb begin
                dly_d[0] = array_out[t];
                for (int k = 1; k < N; k++) dly_d[k] = dly_q[k-1];
            end
            always_ff @(posedge clk) dly_q <= dly_d;
            assign aligned[t] = dly_q[N-1];
        end
    end

    always_comb begin
        for (int t = 0; t < LANES; t++) begin
`ifdef SYS_COLLECT_RELU_EN
            wr_data[t] = aligned[t][RW-1] ? '0 : aligned[t];
`else
            wr_data[t] = aligned[t];
`endif
        end
    end

    // Credit is computed from registered occupancy only, keeping res_ready off this path.
    always_comb begin
        inflight = '0;
        for (int k = 0; k < TL; k++) inflight = inflight + OCC_W'(tag_q[k]);
        fifo_cnt  = mem_cnt_q + OCC_W'(res_valid_q);
        vec_ready = (state_q == RUN) && (issued_q < frame_len_q) &&
                    ((fifo_cnt + inflight) < OCC_W'(FIFO_DEPTH));
        issue     = vec_valid && vec_ready;
        tag_d     = (tag_q << 1) | TL'(issue);
        wr_en     = tag_q[TL-1];
        wr_last   = (written_q == frame_len_q - LEN_W'(1));
        pop       = res_valid_q && res_ready;
    end

    // The output register is the FIFO head; an empty FIFO is bypassed straight into it.
    always_comb begin
        res_valid_d = res_valid_q;
        res_last_d  = res_last_q;
        res_data_d  = res_data_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        load_out    = !res_valid_q || pop;
        mem_rd      = load_out && (mem_cnt_q != '0);
        mem_we      = wr_en && !(load_out && (mem_cnt_q == '0));
        if (load_out) begin
            if (mem_cnt_q != '0) begin
                {res_last_d, res_data_d} = mem_q[rd_ptr_q];
                res_valid_d = 1'b1;
                rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            end else if (wr_en) begin
                {res_last_d, res_data_d} = {wr_last, wr_data};
                res_valid_d = 1'b1;
            end else begin
                res_valid_d = 1'b0;
            end
        end
        if (mem_we) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        mem_cnt_d = mem_cnt_q + OCC_W'(mem_we) - OCC_W'(mem_rd);
    end

    always_comb begin
        state_d     = state_q;
        frame_len_d = frame_len_q;
        issued_d    = issued_q + LEN_W'(issue);
        written_d   = written_q + LEN_W'(wr_en);
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    frame_len_d = frame_len;
                    issued_d    = '0;
                    written_d   = '0;
                    if (frame_len == '0) done_d  = 1'b1;
                    else                 state_d = RUN;
                end
            end
            RUN: begin
                if (issued_q == frame_len_q) state_d = DRAIN;
            end
            DRAIN: begin
                if ((written_q == frame_len_q) && (fifo_cnt == '0)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wr_ptr_q] <= {wr_last, wr_data};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            frame_len_q <= '0;
            issued_q    <= '0;
            written_q   <= '0;
            tag_q       <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            mem_cnt_q   <= '0;
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
            res_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_len_q <= frame_len_d;
            issued_q    <= issued_d;
            written_q   <= written_d;
            tag_q       <= tag_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            mem_cnt_q   <= mem_cnt_d;
            res_valid_q <= res_valid_d;
            res_last_q  <= res_last_d;
            res_data_q  <= res_data_d;
            done_q      <= done_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_last  = res_last_q;
    assign done      = done_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sys_array_result_collector.sv
// Bench for sys_array_result_collector: models the skewed array outputs, scoreboards the
// result stream and runs directed single-vector vectors plus multi-cycle frame sequences.
module tb_sys_array_result_collector;

    localparam int DW       = 8;
    localparam int LANES    = 4;
    localparam int PIPE_LAT = 4;
    localparam int DEPTH    = 8;
    localparam int LEN_W    = 16;
    localparam int RW       = 2 * DW;
    localparam int HL       = PIPE_LAT + LANES - 1;

    typedef logic [LANES-1:0][RW-1:0] vec_t;

    typedef struct {
        vec_t  lanes;
        vec_t  expv;
        string name;
    } vec_rec_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [LEN_W-1:0] frame_len;
    logic             vec_valid;
    logic             vec_ready;
    vec_t             array_out;
    logic             res_valid;
    logic             res_ready;
    vec_t             res_data;
    logic             res_last;
    logic             busy;
    logic             done;

    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;
    int   issue_edge = 0;
    int   n_issued = 0;
    int   n_popped = 0;
    int   n_done = 0;
    int   n_last = 0;
    int   frame_base = 0;
    int   cur_len = 0;
    bit   stream_mode = 1'b0;
    vec_t drive_vec = '0;
    vec_t cap_pay;

    logic hist_v [HL];
    vec_t hist_d [HL];
    vec_t exp_q[$];
    bit   exp_last_q[$];

    vec_t prev_data;
    logic prev_last;
    bit   prev_stall = 1'b0;

    vec_rec_t tbl [3];

    sys_array_result_collector #(
        .DATA_WIDTH(DW), .LANES(LANES), .PIPE_LAT(PIPE_LAT), .FIFO_DEPTH(DEPTH), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .frame_len(frame_len),
        .vec_valid(vec_valid), .vec_ready(vec_ready), .array_out(array_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_last(res_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic vec_t gen_vec(input int n);
        vec_t v;
        for (int t = 0; t < LANES; t++) v[t] = 16'(16'h0200 + n * 16 + t);
        return v;
    endfunction

    function automatic vec_t relu_vec(input vec_t v);
        vec_t r;
        for (int t = 0; t < LANES; t++) begin
`ifdef SYS_COLLECT_RELU_EN
            r[t] = v[t][RW-1] ? 16'h0000 : v[t];
`else
            r[t] = v[t];
`endif
        end
        return r;
    endfunction

    // Array model: an issue at cycle c shows up on lane t during cycle c+PIPE_LAT+t.
    always @(posedge clk) begin
        edge_n <= edge_n + 1;
        if (reset) begin
            for (int k = 0; k < HL; k++) hist_v[k] <= 1'b0;
            exp_q.delete();
            exp_last_q.delete();
        end else begin
            for (int k = HL - 1; k > 0; k--) begin
                hist_v[k] <= hist_v[k-1];
                hist_d[k] <= hist_d[k-1];
            end
            cap_pay = stream_mode ? gen_vec(n_issued) : drive_vec;
            hist_v[0] <= vec_valid && vec_ready;
            hist_d[0] <= cap_pay;
            if (vec_valid && vec_ready) begin
                exp_q.push_back(relu_vec(cap_pay));
                exp_last_q.push_back((n_issued - frame_base) == cur_len - 1);
                n_issued   <= n_issued + 1;
                issue_edge <= edge_n + 1;
            end
        end
    end

    always_comb begin
        for (int t = 0; t < LANES; t++)
            array_out[t] = hist_v[PIPE_LAT-1+t] ? hist_d[PIPE_LAT-1+t][t] : 16'hDEAD;
    end

    // Stream monitor: scoreboard on every transfer and hold checks while stalled.
    always @(negedge clk) begin
        vec_t e;
        bit   l;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!res_valid || res_data !== prev_data || res_last !== prev_last) begin
                    errors++;
                    $display("[TB] FAIL stall_hold: got valid=%0b data=%h last=%0b required valid=1 data=%h last=%0b",
                             res_valid, res_data, res_last, prev_data, prev_last);
                end
            end
            if (res_valid && res_ready) begin
                checks++;
                n_popped++;
                if (res_last) n_last++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_vector: got data=%h with nothing outstanding", res_data);
                end else begin
                    e = exp_q.pop_front();
                    l = exp_last_q.pop_front();
                    if (res_data !== e || res_last !== l) begin
                        errors++;
                        $display("[TB] FAIL scoreboard: got data=%h last=%0b required data=%h last=%0b",
                                 res_data, res_last, e, l);
                    end
                end
            end
            if (done) n_done++;
            prev_stall = res_valid && !res_ready;
            prev_data  = res_data;
            prev_last  = res_last;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Pulses start for one cycle; returns just after the edge that sampled it.
    task automatic applyStimulus(input int len);
        start      = 1'b1;
        frame_len  = LEN_W'(len);
        cur_len    = len;
        frame_base = n_issued;
        tick();
        start = 1'b0;
    endtask

    task automatic waitDone(input int bound, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic runSingle(input vec_t v, input vec_t e, input string name);
        bit found;
        bit seen;
        res_ready   = 1'b1;
        stream_mode = 1'b0;
        drive_vec   = v;
        applyStimulus(1);
        checkOutput({name, "_vec_ready"}, 64'(vec_ready), 64'd1);
        vec_valid = 1'b1;
        tick();
        vec_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (res_valid) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput({name, "_res_valid_seen"}, 64'(found), 64'd1);
        checkOutput({name, "_latency"}, 64'(edge_n - issue_edge), 64'd7);
        checkOutput({name, "_data"}, 64'(res_data), 64'(e));
        checkOutput({name, "_last"}, 64'(res_last), 64'd1);
        waitDone(12, seen);
        checkOutput({name, "_done_seen"}, 64'(seen), 64'd1);
        @(negedge clk);
        checkOutput({name, "_done_width"}, 64'(done), 64'd0);
        checkOutput({name, "_busy_after"}, 64'(busy), 64'd0);
        tick();
    endtask

    initial begin
        bit seen;
        int d0, p0, l0, i;

        tbl[0].lanes = {16'd103, 16'd102, 16'd101, 16'd100};
        tbl[0].expv  = {16'd103, 16'd102, 16'd101, 16'd100};
        tbl[0].name  = "vec_ramp";
        tbl[1].lanes = {16'h8000, 16'h7FFF, 16'h0000, 16'hFFFB};
        tbl[2].lanes = {16'h0005, 16'h1234, 16'hFFFF, 16'h0001};
`ifdef SYS_COLLECT_RELU_EN
        tbl[1].expv  = {16'h0000, 16'h7FFF, 16'h0000, 16'h0000};
        tbl[2].expv  = {16'h0005, 16'h1234, 16'h0000, 16'h0001};
`else
        tbl[1].expv  = {16'h8000, 16'h7FFF, 16'h0000, 16'hFFFB};
        tbl[2].expv  = {16'h0005, 16'h1234, 16'hFFFF, 16'h0001};
`endif
        tbl[1].name  = "vec_neg";
        tbl[2].name  = "vec_mixed";

        reset     = 1'b1;
        start     = 1'b0;
        frame_len = '0;
        vec_valid = 1'b0;
        res_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_res_valid", 64'(res_valid), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_vec_ready", 64'(vec_ready), 64'd0);
        checkOutput("reset_res_last", 64'(res_last), 64'd0);
        tick();

        for (int k = 0; k < 3; k++) runSingle(tbl[k].lanes, tbl[k].expv, tbl[k].name);

        $display("[TB] credit backpressure frame");
        stream_mode = 1'b1;
        res_ready   = 1'b0;
        applyStimulus(20);
        vec_valid = 1'b1;
        repeat (30) tick();
        checkOutput("credit_issues", 64'(n_issued - frame_base), 64'd8);
        checkOutput("credit_vec_ready", 64'(vec_ready), 64'd0);
        checkOutput("credit_busy", 64'(busy), 64'd1);
        d0 = n_done; p0 = n_popped; l0 = n_last;
        res_ready = 1'b1;
        waitDone(300, seen);
        vec_valid = 1'b0;
        checkOutput("credit_done_seen", 64'(seen), 64'd1);
        @(negedge clk);
        checkOutput("credit_popped", 64'(n_popped - p0), 64'd20);
        checkOutput("credit_last_count", 64'(n_last - l0), 64'd1);
        checkOutput("credit_done_count", 64'(n_done - d0), 64'd1);
        checkOutput("credit_leftover", 64'(exp_q.size()), 64'd0);
        tick();

        $display("[TB] random backpressure frame");
        d0 = n_done; p0 = n_popped; l0 = n_last;
        applyStimulus(24);
        vec_valid = 1'b1;
        i = 0;
        while (n_done == d0 && i < 800) begin
            res_ready = 1'($urandom_range(0, 1));
            tick();
            i++;
        end
        vec_valid = 1'b0;
        res_ready = 1'b1;
        checkOutput("random_done_count", 64'(n_done - d0), 64'd1);
        checkOutput("random_popped", 64'(n_popped - p0), 64'd24);
        checkOutput("random_last_count", 64'(n_last - l0), 64'd1);
        checkOutput("random_leftover", 64'(exp_q.size()), 64'd0);
        tick();

        $display("[TB] reset during drain");
        res_ready = 1'b0;
        d0 = n_done;
        applyStimulus(3);
        vec_valid = 1'b1;
        repeat (15) tick();
        vec_valid = 1'b0;
        checkOutput("drain_busy", 64'(busy), 64'd1);
        checkOutput("drain_res_valid", 64'(res_valid), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("postreset_res_valid", 64'(res_valid), 64'd0);
        checkOutput("postreset_busy", 64'(busy), 64'd0);
        checkOutput("postreset_done", 64'(done), 64'd0);
        @(negedge clk);
        checkOutput("postreset_done_later", 64'(done), 64'd0);
        checkOutput("postreset_done_count", 64'(n_done - d0), 64'd0);
        tick();
        runSingle(tbl[0].lanes, tbl[0].expv, "after_reset");

        $display("[TB] zero-length frame and ignored start");
        d0 = n_done; p0 = n_popped;
        applyStimulus(0);
        @(negedge clk);
        checkOutput("zero_done", 64'(done), 64'd1);
        checkOutput("zero_busy", 64'(busy), 64'd0);
        checkOutput("zero_res_valid", 64'(res_valid), 64'd0);
        @(negedge clk);
        checkOutput("zero_done_width", 64'(done), 64'd0);
        checkOutput("zero_done_count", 64'(n_done - d0), 64'd1);
        checkOutput("zero_popped", 64'(n_popped - p0), 64'd0);
        tick();

        d0 = n_done; p0 = n_popped; l0 = n_last;
        stream_mode = 1'b1;
        res_ready   = 1'b1;
        applyStimulus(4);
        vec_valid = 1'b1;
        tick();
        start     = 1'b1;
        frame_len = LEN_W'(1);
        tick();
        start = 1'b0;
        waitDone(100, seen);
        vec_valid = 1'b0;
        checkOutput("restart_done_seen", 64'(seen), 64'd1);
        @(negedge clk);
        checkOutput("restart_popped", 64'(n_popped - p0), 64'd4);
        checkOutput("restart_last_count", 64'(n_last - l0), 64'd1);
        checkOutput("restart_done_count", 64'(n_done - d0), 64'd1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
